firebird7_in_gate2_tessent_sib_sri_secure_ctrl: RTL and testbench

Keyed secure segment-insertion-bit (SIB) controller for the firebird7_in gate2 IJTAG network. It owns a KEY_WIDTH-bit key register plus one SIB bit in the scan path. It drives `mux_select` of the downstream secure scan mux, which opens or closes the protected sub-segment. The sub-segment opens only after a matching key is applied at update, and a sticky lockout engages after repeated wrong keys.

---
 rtl/firebird7_in_gate2_tessent_sib_sri_secure_ctrl_if.sv | 26 ++
 rtl/firebird7_in_gate2_tessent_sib_sri_secure_ctrl.sv | 140 ++++++++++++++
 tb/tb_firebird7_in_gate2_tessent_sib_sri_secure_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/firebird7_in_gate2_tessent_sib_sri_secure_ctrl_if.sv
// Scan-side and status signals of the keyed secure SIB controller.
// The master drives the IJTAG enables and scan-in; the slave returns scan-out and lock state.
interface firebird7_in_gate2_tessent_sib_sri_secure_ctrl_if #(
  parameter int unsigned CNT_W = 2
);
  logic             ijtag_sel;
  logic             ijtag_ce;
  logic             ijtag_se;
  logic             ijtag_ue;
  logic             ijtag_si;
  logic             ijtag_so;
  logic             mux_select;
  logic             unlocked;
  logic             lockout;
  logic [CNT_W-1:0] fail_count;

  modport master (
    output ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si,
    input  ijtag_so, mux_select, unlocked, lockout, fail_count
  );

  modport slave (
    input  ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si,
    output ijtag_so, mux_select, unlocked, lockout, fail_count
  );
endinterface

// File: rtl/firebird7_in_gate2_tessent_sib_sri_secure_ctrl.sv
// Keyed secure SIB: opens the protected sub-segment only after a matching key update,
// with sticky lockout after MAX_FAILS wrong keys. FIREBIRD7_IN_GATE2_SIB_STATUS_CAPTURE_EN adds status capture.
module firebird7_in_gate2_tessent_sib_sri_secure_ctrl #(
  parameter int unsigned             KEY_WIDTH = 16,
  parameter int unsigned             CNT_W     = 2,
  parameter int unsigned             MAX_FAILS = 3,
  parameter logic [KEY_WIDTH-1:0]    KEY_VALUE = KEY_WIDTH'(16'hA5C3)
) (
  input logic ijtag_tck,
  input logic ijtag_reset,
  firebird7_in_gate2_tessent_sib_sri_secure_ctrl_if.slave bus
);

  localparam logic [1:0] LOCKED   = 2'd0;
  localparam logic [1:0] UNLOCKED = 2'd1;
  localparam logic [1:0] LOCKOUT  = 2'd2;

  localparam logic [CNT_W-1:0] FAIL_MAX = CNT_W'(MAX_FAILS);

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [KEY_WIDTH-1:0] key_sr;
  logic [KEY_WIDTH-1:0] key_nxt;
  logic                 sib_sr;
  logic                 sib_nxt;
  logic                 mux_select;
  logic                 mux_nxt;
  logic [CNT_W-1:0]     fail_count;
  logic [CNT_W-1:0]     fail_nxt;
  logic [CNT_W-1:0]     fail_inc;
  logic                 unlocked;
  logic                 lockout;
  logic [KEY_WIDTH-1:0] status_word;

  logic cap_en;
  logic shf_en;
  logic upd_en;
  logic key_ok;
  logic key_zero;

  assign cap_en   = bus.ijtag_sel & bus.ijtag_ce;
  assign shf_en   = bus.ijtag_sel & bus.ijtag_se & ~bus.ijtag_ce;
  assign upd_en   = bus.ijtag_sel & bus.ijtag_ue;
  assign key_ok   = (key_sr == KEY_VALUE);
  assign key_zero = (key_sr == '0);
  assign fail_inc = fail_count + CNT_W'(1);

  // Word loaded into the key register on capture
  always_comb begin
    status_word = '0;
`ifdef FIREBIRD7_IN_GATE2_SIB_STATUS_CAPTURE_EN
    status_word[0]         = unlocked;
    status_word[1]         = lockout;
    status_word[CNT_W+1:2] = fail_count;
`endif
  end

  // Scan path: capture takes priority over shift
  always_comb begin
    key_nxt = key_sr;
    sib_nxt = sib_sr;
    if (cap_en) begin
      key_nxt = status_word;
      sib_nxt = mux_select;
    end else if (shf_en) begin
      key_nxt = {bus.ijtag_si, key_sr[KEY_WIDTH-1:1]};
      sib_nxt = key_sr[0];
    end
  end

  // Lock FSM next state and registered-output next values; update sees pre-edge key/sib
  always_comb begin
    state_nxt = state;
    mux_nxt   = mux_select;
    fail_nxt  = fail_count;
    case (state)
      LOCKED: begin
        mux_nxt = 1'b0;
        if (upd_en) begin
          if (key_ok) begin
            state_nxt = UNLOCKED;
            mux_nxt   = sib_sr;
            fail_nxt  = '0;
          end else if (!key_zero && (fail_count < FAIL_MAX)) begin
            fail_nxt = fail_inc;
            if (fail_inc == FAIL_MAX) begin
              state_nxt = LOCKOUT;
            end
          end
        end
      end
      UNLOCKED: begin
        if (upd_en) begin
          if (key_zero) begin
            state_nxt = LOCKED;
            mux_nxt   = 1'b0;
          end else begin
            mux_nxt = sib_sr;
          end
        end
      end
      LOCKOUT: begin
        mux_nxt  = 1'b0;
        fail_nxt = FAIL_MAX;
      end
      default: begin
        state_nxt = LOCKED;
        mux_nxt   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides every enable
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state      <= LOCKED;
      key_sr     <= '0;
      sib_sr     <= 1'b0;
      mux_select <= 1'b0;
      fail_count <= '0;
      unlocked   <= 1'b0;
      lockout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      key_sr     <= key_nxt;
      sib_sr     <= sib_nxt;
      mux_select <= mux_nxt;
      fail_count <= fail_nxt;
      unlocked   <= (state_nxt == UNLOCKED);
      lockout    <= (state_nxt == LOCKOUT);
    end
  end

  assign bus.ijtag_so   = sib_sr;
  assign bus.mux_select = mux_select;
  assign bus.unlocked   = unlocked;
  assign bus.lockout    = lockout;
  assign bus.fail_count = fail_count;

endmodule

// File: tb/tb_firebird7_in_gate2_tessent_sib_sri_secure_ctrl.sv
// Scoreboard bench for the keyed secure SIB controller: stimulus pushes expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_firebird7_in_gate2_tessent_sib_sri_secure_ctrl;

  localparam int unsigned KW = 16;

  typedef struct {
    string      name;
    bit         is_so;
    logic [4:0] exp;
  } exp_t;

  logic tck = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 tck = ~tck;

  firebird7_in_gate2_tessent_sib_sri_secure_ctrl_if #(.CNT_W(2)) bus ();

  firebird7_in_gate2_tessent_sib_sri_secure_ctrl dut (
    .ijtag_tck   (tck),
    .ijtag_reset (rst),
    .bus         (bus)
  );

  // Monitor: outputs are stable at negedge; check everything pushed since the last edge
  initial begin
    exp_t       e;
    logic [4:0] act;
    forever begin
      @(negedge tck);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.is_so) act = {4'b0, bus.ijtag_so};
        else         act = {bus.mux_select, bus.unlocked, bus.lockout, bus.fail_count};
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %b expected %b (mux,unl,lock,fail[1:0] or so)", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic idle();
    bus.ijtag_sel = 1'b0;
    bus.ijtag_ce  = 1'b0;
    bus.ijtag_se  = 1'b0;
    bus.ijtag_ue  = 1'b0;
    bus.ijtag_si  = 1'b0;
  endtask

  task automatic expect_st(input string n, input logic m, input logic u, input logic l,
                           input logic [1:0] f);
    exp_t e;
    e.name  = n;
    e.is_so = 1'b0;
    e.exp   = {m, u, l, f};
    sb.push_back(e);
  endtask

  task automatic expect_so(input string n, input logic b);
    exp_t e;
    e.name  = n;
    e.is_so = 1'b1;
    e.exp   = {4'b0, b};
    sb.push_back(e);
  endtask

  task automatic do_reset(input string n);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_st(n, 1'b0, 1'b0, 1'b0, 2'd0);
    expect_so({n, "_so"}, 1'b0);
  endtask

  // SIB bit first, then key LSB first: KW+1 shift edges
  task automatic shift_key(input logic b, input logic [KW-1:0] key);
    bus.ijtag_sel = 1'b1;
    bus.ijtag_se  = 1'b1;
    for (int i = 0; i <= int'(KW); i++) begin
      bus.ijtag_si = (i == 0) ? b : key[i-1];
      tick();
    end
    idle();
  endtask

  task automatic do_update();
    bus.ijtag_sel = 1'b1;
    bus.ijtag_ue  = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    logic [KW-1:0] st;
`ifdef FIREBIRD7_IN_GATE2_SIB_STATUS_CAPTURE_EN
    st = 16'h0008;
`else
    st = 16'h0000;
`endif
    idle();
    do_reset("reset");

    // Correct key unlocks and opens the mux
    shift_key(1'b1, 16'hA5C3); do_update(); expect_st("unlock", 1, 1, 0, 2'd0);
    shift_key(1'b0, 16'h0000); do_update(); expect_st("relock", 0, 0, 0, 2'd0);

    // Three wrong keys reach lockout; correct key then ignored
    shift_key(1'b1, 16'h1234); do_update(); expect_st("fail1", 0, 0, 0, 2'd1);
    do_update();                            expect_st("fail2", 0, 0, 0, 2'd2);
    do_update();                            expect_st("fail3_lockout", 0, 0, 1, 2'd3);
    shift_key(1'b1, 16'hA5C3); do_update(); expect_st("lockout_ignores_key", 0, 0, 1, 2'd3);
    do_reset("reset_exit_lockout");

    // Zero key in LOCKED is a no-op
    shift_key(1'b1, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      do_update();
      expect_st($sformatf("zero_key_%0d", i), 0, 0, 0, 2'd0);
    end

    // Unlocked: nonzero key updates mux from SIB bit, zero key relocks
    shift_key(1'b1, 16'hA5C3); do_update(); expect_st("unlock2", 1, 1, 0, 2'd0);
    shift_key(1'b0, 16'hFFFF); do_update(); expect_st("sib0_close", 0, 1, 0, 2'd0);
    shift_key(1'b0, 16'h0000); do_update(); expect_st("zero_relock", 0, 0, 0, 2'd0);

    // Status capture after two fails, then shift it out
    shift_key(1'b1, 16'h1234); do_update(); expect_st("cap_fail1", 0, 0, 0, 2'd1);
    do_update();                            expect_st("cap_fail2", 0, 0, 0, 2'd2);
    bus.ijtag_sel = 1'b1;
    bus.ijtag_ce  = 1'b1;
    tick();
    idle();
    expect_so("cap_sib", 1'b0);
    bus.ijtag_sel = 1'b1;
    bus.ijtag_se  = 1'b1;
    for (int k = 0; k < int'(KW); k++) begin
      tick();
      expect_so($sformatf("cap_bit%0d", k), st[k]);
    end
    idle();

    // ce+se+ue together: capture wins in the scan path, update uses the pre-edge key
    do_reset("reset_combo");
    shift_key(1'b1, 16'hA5C3);
    expect_so("combo_pre_so", 1'b1);
    bus.ijtag_sel = 1'b1;
    bus.ijtag_ce  = 1'b1;
    bus.ijtag_se  = 1'b1;
    bus.ijtag_ue  = 1'b1;
    tick();
    idle();
    expect_st("combo_update", 1, 1, 0, 2'd0);
    expect_so("combo_cap_so", 1'b0);
    do_update();
    expect_st("combo_captured_key_zero", 0, 0, 0, 2'd0);

    // Same with sel low: nothing changes
    shift_key(1'b1, 16'hA5C3);
    bus.ijtag_ce = 1'b1;
    bus.ijtag_se = 1'b1;
    bus.ijtag_ue = 1'b1;
    bus.ijtag_si = 1'b0;
    tick();
    idle();
    expect_st("nosel_state", 0, 0, 0, 2'd0);
    expect_so("nosel_so", 1'b1);
    do_update();
    expect_st("nosel_key_kept", 1, 1, 0, 2'd0);

    // Reset wins over a simultaneous update
    shift_key(1'b0, 16'h0000);
    bus.ijtag_sel = 1'b1;
    bus.ijtag_ue  = 1'b1;
    do_reset("reset_over_update");
    idle();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
